cpu_pipe_ctrl: RTL

//  Parametrised pipeline control/hazard unit for the cpu core. Keeps a shadow of the NUM_STAGES post-decode

---
 rtl/cpu_pipe_ctrl_if.sv | 46 ++++
 rtl/cpu_pipe_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cpu_pipe_ctrl_if.sv
// Decode-side hazard inputs and pipe-control outputs of the cpu pipeline control unit.
// master = core/decode side, slave = the control unit.
interface cpu_pipe_ctrl_if #(
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 4,
    parameter int CNT_W      = 16
) ();
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    logic             id_valid;
    logic             id_src1_en;
    logic [REG_W-1:0] id_src1;
    logic             id_src2_en;
    logic [REG_W-1:0] id_src2;
    logic             id_wrt_en;
    logic [REG_W-1:0] id_wrt_reg;
    logic             id_is_load;
    logic             ex_jb_taken;
    logic             mem_stall;

    logic                  if_en;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_en;
    logic                  idex_bubble;
    logic                  exmem_en;
    logic [NUM_STAGES-1:0] stage_valid;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_valid, id_src1_en, id_src1, id_src2_en, id_src2,
               id_wrt_en, id_wrt_reg, id_is_load, ex_jb_taken, mem_stall,
        input  if_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               stage_valid, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1_en, id_src1, id_src2_en, id_src2,
               id_wrt_en, id_wrt_reg, id_is_load, ex_jb_taken, mem_stall,
        output if_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
               stage_valid, fwd_sel1, fwd_sel2, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/cpu_pipe_ctrl.sv
// Pipeline hazard/control unit: shadows post-decode stages, drives pipe enables, bubbles,
// flushes and forwarding selects; counts RAW stall cycles and branch flushes.
module cpu_pipe_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 4,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    cpu_pipe_ctrl_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_STAGES + 1);

    typedef struct packed {
        logic             vld;
        logic             wrt_en;
        logic [REG_W-1:0] wrt_reg;
        logic             is_load;
    } stage_t;

    stage_t           stage_q [NUM_STAGES];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             hit1, hit2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             raw_stall;

    // Scan oldest to youngest so the youngest matching producer is the one kept.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (bus.id_src1_en && stage_q[i].vld && stage_q[i].wrt_en &&
                stage_q[i].wrt_reg == bus.id_src1) begin
                hit1 = 1'b1;
                sel1 = SEL_W'(i + 1);
            end
            if (bus.id_src2_en && stage_q[i].vld && stage_q[i].wrt_en &&
                stage_q[i].wrt_reg == bus.id_src2) begin
                hit2 = 1'b1;
                sel2 = SEL_W'(i + 1);
            end
        end
    end

    always_comb begin
        raw_stall = 1'b0;
        if (FWD_EN == 0) begin
            raw_stall = bus.id_valid && (hit1 || hit2);
        end else begin
            raw_stall = bus.id_valid && stage_q[0].is_load &&
                        ((hit1 && sel1 == SEL_W'(1)) || (hit2 && sel2 == SEL_W'(1)));
        end
    end

    always_comb begin
        bus.fwd_sel1 = '0;
        bus.fwd_sel2 = '0;
        if (FWD_EN != 0) begin
            bus.fwd_sel1 = sel1;
            bus.fwd_sel2 = sel2;
        end
    end

    // Priority: reset > mem_stall > ex_jb_taken > raw_stall > normal.
    always_comb begin
        bus.if_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_en     = 1'b1;
        bus.idex_bubble = 1'b0;
        bus.exmem_en    = 1'b1;
        if (!rst_n) begin
            bus.if_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_en     = 1'b0;
            bus.idex_bubble = 1'b1;
            bus.exmem_en    = 1'b0;
        end else if (bus.mem_stall) begin
            bus.if_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
        end else if (bus.ex_jb_taken) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (raw_stall) begin
            bus.if_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!bus.mem_stall) begin
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            if (bus.ex_jb_taken) begin
                stage_q[0] <= '0;
                if (flush_cnt_q != {CNT_W{1'b1}}) begin
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
            end else if (raw_stall) begin
                stage_q[0] <= '0;
                if (stall_cnt_q != {CNT_W{1'b1}}) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
            end else begin
                stage_q[0] <= '{bus.id_valid, bus.id_wrt_en, bus.id_wrt_reg, bus.id_is_load};
            end
        end
    end

    always_comb begin
        bus.stage_valid = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bus.stage_valid[i] = stage_q[i].vld;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule
